// File: rtl/echo_width_meter_pkg.sv
// Shared definitions for the echo width meter: FSM state encoding and default
// counter width, kept in step with the timeout waiter.
package echo_width_meter_pkg;

  localparam int unsigned CNT_LEN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    MEASURING = 2'd2,
    DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/echo_width_meter_sync.sv
// echo_sync_filter: brings the asynchronous echo into the clk domain and, when
// ECHO_GLITCH_FILTER_EN is defined, rejects pulses/gaps shorter than FILTER_LEN.
// Both edges see the same latency, so measured widths are unaffected.
module echo_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic echo_i,
  output logic echo_f_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   echo_s;

  // Synchroniser shift chain; the last stage is the clean echo_s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], echo_i};
  end

  assign echo_s = sync_q[SYNC_STAGES-1];

`ifdef ECHO_GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] run_q, run_d;
  logic          filt_q, filt_d;

  // Count consecutive cycles where echo_s disagrees with the filtered level;
  // flip the level on the FILTER_LEN-th such cycle.
  always_comb begin
    run_d  = '0;
    filt_d = filt_q;
    if (echo_s != filt_q) begin
      if (run_q == FW'(FILTER_LEN - 1)) begin
        filt_d = echo_s;
        run_d  = '0;
      end else begin
        run_d = run_q + FW'(1);
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      filt_q <= filt_d;
    end
  end

  assign echo_f_o = filt_q;
`else
  // Filter length only matters when the filter is built.
  if (FILTER_LEN == 0) begin : g_no_filter
  end

  assign echo_f_o = echo_s;
`endif

endmodule

// File: rtl/echo_width_meter.sv
// echo_width_meter: armed by start, waits for a rising edge on echo, then
// counts its high time in clk cycles. max_count bounds both the wait and the
// measurement. Optional glitch filter: define ECHO_GLITCH_FILTER_EN.
module echo_width_meter
  import echo_width_meter_pkg::*;
#(
  parameter int unsigned CNT_LEN     = CNT_LEN_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_LEN-1:0] max_count,
  input  logic               echo,
  output logic               busy,
  output logic               valid,
  output logic [CNT_LEN-1:0] width,
  output logic               overflow
);

  state_e             state_q, state_d;
  logic [CNT_LEN-1:0] lim_q, lim_d;
  logic [CNT_LEN-1:0] cnt_q, cnt_d;
  logic [CNT_LEN-1:0] width_q, width_d;
  logic               ovf_q, ovf_d;
  logic               echo_f, echo_f_d_q, rise;

  echo_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .echo_i  (echo),
    .echo_f_o(echo_f)
  );

  assign rise = echo_f & ~echo_f_d_q;

  // Next state, counters and result registers.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          lim_d   = max_count;
          cnt_d   = '0;
          width_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        // A zero limit times out immediately, even if an edge arrives.
        if (lim_q == '0) begin
          state_d = DONE;
          ovf_d   = 1'b1;
          width_d = '0;
        end else if (rise) begin
          state_d = MEASURING;
          cnt_d   = CNT_LEN'(1);
        end else if (cnt_q == lim_q) begin
          state_d = DONE;
          ovf_d   = 1'b1;
          width_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_LEN'(1);
        end
      end
      MEASURING: begin
        if (!echo_f) begin
          state_d = DONE;
          width_d = cnt_q;
        end else if (cnt_q == lim_q) begin
          state_d = DONE;
          width_d = lim_q;
          ovf_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_LEN'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and edge-detect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lim_q      <= '0;
      cnt_q      <= '0;
      width_q    <= '0;
      ovf_q      <= 1'b0;
      echo_f_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lim_q      <= lim_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      ovf_q      <= ovf_d;
      echo_f_d_q <= echo_f;
    end
  end

  assign busy     = (state_q != IDLE);
  assign valid    = (state_q == DONE);
  assign width    = width_q;
  assign overflow = ovf_q;

endmodule
